// File: rtl/vga_timing_pkg.sv
// VGA raster timing constants and shared pixel format.
// Default mode is 640x480@60 with one pixel per enabled clock.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    // Timing sums are kept in 11 bits so an oversize mode stays detectable.
    function automatic logic [10:0] sum11(input int unsigned a,
                                          input int unsigned b);
        return 11'(a) + 11'(b);
    endfunction

    localparam logic [10:0] H_TOTAL =
        sum11(sum11(H_ACTIVE, H_FP), sum11(H_SYNC, H_BP));
    localparam logic [10:0] V_TOTAL =
        sum11(sum11(V_ACTIVE, V_FP), sum11(V_SYNC, V_BP));

    localparam logic [10:0] HSYNC_START = sum11(H_ACTIVE, H_FP);
    localparam logic [10:0] HSYNC_END   = sum11(HSYNC_START, H_SYNC);
    localparam logic [10:0] VSYNC_START = sum11(V_ACTIVE, V_FP);
    localparam logic [10:0] VSYNC_END   = sum11(VSYNC_START, V_SYNC);

    // Pattern blocks drive rgb as {R1,G1,B1,R0,G0,B0}.
    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r0;
        logic g0;
        logic b0;
    } rgb_t;

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Enable-qualified counter that wraps from MAX to 0.
// Reset parks it on MAX so the first enabled step lands on 0.
module wrap_counter #(
    parameter logic [9:0] MAX = 10'd799
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic [9:0] count,
    output logic       wrap
);

    logic [9:0] count_d;
    logic [9:0] count_q;

    assign wrap  = (count_q == MAX);
    assign count = count_q;

    // Next count: step when enabled, fold back to 0 after MAX.
    always_comb begin
        count_d = count_q;
        if (ce) begin
            count_d = wrap ? 10'd0 : count_q + 10'd1;
        end
    end

    // Count register, parked on the last position by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MAX;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: coordinates, active flag, syncs and frame strobe.
// Every output is a flop decoded from the next counter values.
module vga_timing_gen
    import vga_timing_pkg::sum11;
#(
    parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       next_frame,
    output logic [9:0] frame_count
);

    localparam logic [10:0] HA  = sum11(H_ACTIVE, 0);
    localparam logic [10:0] VA  = sum11(V_ACTIVE, 0);
    localparam logic [10:0] HT  =
        sum11(sum11(H_ACTIVE, H_FP), sum11(H_SYNC, H_BP));
    localparam logic [10:0] VT  =
        sum11(sum11(V_ACTIVE, V_FP), sum11(V_SYNC, V_BP));
    localparam logic [10:0] HSS = sum11(H_ACTIVE, H_FP);
    localparam logic [10:0] HSE = sum11(HSS, H_SYNC);
    localparam logic [10:0] VSS = sum11(V_ACTIVE, V_FP);
    localparam logic [10:0] VSE = sum11(VSS, V_SYNC);

    localparam logic [9:0] H_MAX = 10'(HT - 11'd1);
    localparam logic [9:0] V_MAX = 10'(VT - 11'd1);

    if (HT > 11'd1024) begin : g_h_too_big
        $error("H_TOTAL exceeds 1024");
    end
    if (VT > 11'd1024) begin : g_v_too_big
        $error("V_TOTAL exceeds 1024");
    end

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       v_ce;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       hs_on;
    logic       vs_on;

    logic [9:0] x_d, x_q;
    logic [9:0] y_d, y_q;
    logic       active_d, active_q;
    logic       hsync_d, hsync_q;
    logic       vsync_d, vsync_q;
    logic       next_frame_d, next_frame_q;
    logic [9:0] frame_count_d, frame_count_q;

    assign v_ce = pixel_ce && h_wrap;

    wrap_counter #(.MAX(H_MAX)) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .ce   (pixel_ce),
        .count(h_cnt),
        .wrap (h_wrap)
    );

    wrap_counter #(.MAX(V_MAX)) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .ce   (v_ce),
        .count(v_cnt),
        .wrap (v_wrap)
    );

    // Counter values the next edge will load, so outputs match them.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (pixel_ce) begin
            h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    // Decode active, syncs and the frame strobe from the next position.
    always_comb begin
        x_d      = h_nxt;
        y_d      = v_nxt;
        active_d = ({1'b0, h_nxt} < HA) && ({1'b0, v_nxt} < VA);
        hs_on    = ({1'b0, h_nxt} >= HSS) && ({1'b0, h_nxt} < HSE);
        vs_on    = ({1'b0, v_nxt} >= VSS) && ({1'b0, v_nxt} < VSE);
        hsync_d  = hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d  = vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        next_frame_d  = v_ce && ({1'b0, v_nxt} == VA);
        frame_count_d = frame_count_q + {9'd0, next_frame_d};
    end

    // Output registers; reset presents the last blanked pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= H_MAX;
            y_q           <= V_MAX;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            next_frame_q  <= 1'b0;
            frame_count_q <= 10'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            next_frame_q  <= next_frame_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign next_frame  = next_frame_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster.
// Expected pixels come from a linear frame-position model.
module tb_vga_timing_gen;

    localparam int HA  = 4;
    localparam int HFP = 1;
    localparam int HS  = 2;
    localparam int HBP = 1;
    localparam int VA  = 3;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixel_ce = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       next_frame;
    logic [9:0] frame_count;

    typedef struct {
        int x;
        int y;
        bit act;
        bit hs;
        bit vs;
        bit nf;
        int fc;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;
    int p = FR - 1;
    int fc = 0;
    int exp_pulses = 0;
    int seen_pulses = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_ce   (pixel_ce),
        .x          (x),
        .y          (y),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .next_frame (next_frame),
        .frame_count(frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Apply one clock of stimulus and queue the pixel it should produce.
    task automatic step(input bit r, input bit ce);
        exp_t e;
        int   xx;
        int   yy;
        rst      = r;
        pixel_ce = ce;
        @(posedge clk);
        e.nf = 1'b0;
        if (r) begin
            p  = FR - 1;
            fc = 0;
        end else if (ce) begin
            p = (p + 1) % FR;
            if (p == VA * HT) begin
                e.nf = 1'b1;
                fc   = (fc + 1) % 1024;
                exp_pulses++;
            end
        end
        xx    = p % HT;
        yy    = p / HT;
        e.x   = xx;
        e.y   = yy;
        e.act = (xx < HA) && (yy < VA);
        e.hs  = !((xx >= HA + HFP) && (xx < HA + HFP + HS));
        e.vs  = !((yy >= VA + VFP) && (yy < VA + VFP + VS));
        e.fc  = fc;
        q.push_back(e);
        #1;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FR + 2 && p != target; i++) begin
            step(1'b0, 1'b1);
        end
    endtask

    // Monitor: compare every presented pixel against the queued model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (next_frame === 1'b1) seen_pulses++;
                chk("x", 32'(x), 32'(e.x));
                chk("y", 32'(y), 32'(e.y));
                chk("active", 32'(active), 32'(e.act));
                chk("hsync", 32'(hsync), 32'(e.hs));
                chk("vsync", 32'(vsync), 32'(e.vs));
                chk("next_frame", 32'(next_frame), 32'(e.nf));
                chk("frame_count", 32'(frame_count), 32'(e.fc));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1);

        for (int i = 0; i < 2 * FR; i++) step(1'b0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 100; i++) step(1'b0, i % 2 == 0);

        run_to(VA * HT - 1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        run_to(1 * HT + 2);
        step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1);

        for (int i = 0; i < 1024 * FR; i++) step(1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("pulse_count", 32'(seen_pulses), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
